// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b widths plus line-buffer types.
// Used by mem_line_bridge and line_merge.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [1:0]   lc3b_mem_wmask;
    typedef logic [127:0] lc3b_line;
    typedef logic [11:0]  lc3b_line_tag;
    typedef logic [2:0]   lc3b_line_offset;

    typedef enum logic [1:0] {
        MLB_IDLE,
        MLB_FILL,
        MLB_WRITE
    } mlb_state_e;

    function automatic lc3b_word line_word(
        input lc3b_line        l,
        input lc3b_line_offset o
    );
        return l[{o, 4'b0000} +: 16];
    endfunction

endpackage

// File: rtl/line_merge.sv
// line_merge: byte-masked merge of one 16-bit word into a 128-bit line.
// Purely combinational; shared with future cache datapaths.
module line_merge
    import lc3b_types::*;
(
    input  logic [127:0] line_in,
    input  logic [2:0]   offset,
    input  logic [1:0]   mask,
    input  logic [15:0]  word,
    output logic [127:0] line_out
);

    lc3b_line   merged;
    logic [6:0] base;

    // overwrite the enabled bytes of the addressed word
    always_comb begin
        merged = line_in;
        base   = {offset, 4'b0000};
        if (mask[0]) merged[base +: 8] = word[7:0];
        if (mask[1]) merged[base + 7'd8 +: 8] = word[15:8];
    end

    assign line_out = merged;

endmodule

// File: rtl/mem_line_bridge.sv
// mem_line_bridge: one-line read buffer, write-through to 128-bit pmem.
// Optional MEM_LINE_BRIDGE_STATS_EN adds hit_count/miss_count outputs.
module mem_line_bridge
    import lc3b_types::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic [15:0]  mem_address,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [1:0]   mem_byte_enable,
    input  logic [15:0]  mem_wdata,
    output logic [15:0]  mem_rdata,
    output logic         mem_resp,
    output logic [15:0]  pmem_address,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp
`ifdef MEM_LINE_BRIDGE_STATS_EN
    ,
    output logic [15:0]  hit_count,
    output logic [15:0]  miss_count
`endif
);

    mlb_state_e      state, state_next;
    lc3b_line        line_q, line_merged;
    lc3b_line_tag    tag_q, fill_tag_q, req_tag;
    lc3b_line_offset req_off;
    logic            valid_q;
    logic            hit, wr_req, rd_req;
    logic            line_load, merge_en, fill_tag_en;

    assign req_tag   = mem_address[15:4];
    assign req_off   = mem_address[3:1];
    assign hit       = valid_q && (tag_q == req_tag);
    assign wr_req    = mem_write;
    assign rd_req    = mem_read && !mem_write;
    assign mem_rdata = line_word(line_q, req_off);

    line_merge u_merge (
        .line_in  (line_q),
        .offset   (req_off),
        .mask     (mem_byte_enable),
        .word     (mem_wdata),
        .line_out (line_merged)
    );

    // state register; reset drops any pmem request at once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= MLB_IDLE;
        else          state <= state_next;
    end

    // next state, handshakes and pmem drive
    always_comb begin
        state_next   = state;
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = 16'h0000;
        pmem_wdata   = '0;
        line_load    = 1'b0;
        merge_en     = 1'b0;
        fill_tag_en  = 1'b0;
        unique case (state)
            MLB_IDLE: begin
                if (wr_req) begin
                    if (!hit) begin
                        fill_tag_en = 1'b1;
                        state_next  = MLB_FILL;
                    end else if (mem_byte_enable == 2'b00) begin
                        mem_resp = 1'b1;
                    end else begin
                        merge_en   = 1'b1;
                        state_next = MLB_WRITE;
                    end
                end else if (rd_req) begin
                    if (hit) begin
                        mem_resp = 1'b1;
                    end else begin
                        fill_tag_en = 1'b1;
                        state_next  = MLB_FILL;
                    end
                end
            end
            MLB_FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {fill_tag_q, 4'b0000};
                if (pmem_resp) begin
                    line_load  = 1'b1;
                    state_next = MLB_IDLE;
                end
            end
            MLB_WRITE: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_q, 4'b0000};
                pmem_wdata   = line_q;
                if (pmem_resp) begin
                    mem_resp   = 1'b1;
                    state_next = MLB_IDLE;
                end
            end
            default: state_next = MLB_IDLE;
        endcase
    end

    // buffered line, its tag and the tag being filled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line_q     <= '0;
            tag_q      <= '0;
            fill_tag_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            if (fill_tag_en) fill_tag_q <= req_tag;
            if (line_load) begin
                line_q  <= pmem_rdata;
                tag_q   <= fill_tag_q;
                valid_q <= 1'b1;
            end else if (merge_en) begin
                line_q <= line_merged;
            end
        end
    end

`ifdef MEM_LINE_BRIDGE_STATS_EN
    logic fill_done_q;

    // a request that needed a fill is not a hit when it finally responds
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fill_done_q <= 1'b0;
            hit_count   <= '0;
            miss_count  <= '0;
        end else begin
            if (fill_tag_en && miss_count != 16'hFFFF)
                miss_count <= miss_count + 16'd1;
            if (mem_resp && !fill_done_q && hit_count != 16'hFFFF)
                hit_count <= hit_count + 16'd1;
            if (line_load)     fill_done_q <= 1'b1;
            else if (mem_resp) fill_done_q <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_mem_line_bridge.sv
// tb_mem_line_bridge: directed + random accesses vs. a line-level model.
// Define MEM_LINE_BRIDGE_STATS_EN to also check the counters.
module tb_mem_line_bridge;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [15:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [1:0]   mem_byte_enable;
    logic [15:0]  mem_wdata;
    logic [15:0]  mem_rdata;
    logic         mem_resp;
    logic [15:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;
`ifdef MEM_LINE_BRIDGE_STATS_EN
    logic [15:0]  hit_count;
    logic [15:0]  miss_count;
`endif

    always #5 clk = ~clk;

    mem_line_bridge dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .pmem_address    (pmem_address),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_wdata      (pmem_wdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp)
`ifdef MEM_LINE_BRIDGE_STATS_EN
        ,
        .hit_count       (hit_count),
        .miss_count      (miss_count)
`endif
    );

    int nvec = 0;
    int nerr = 0;

    // reference model: buffered line + backing memory, in plain terms
    logic         mvalid;
    logic [11:0]  mtag;
    logic [127:0] mline;
    logic [127:0] bmem [int];
    int           mhits;
    int           mmiss;

    // what the bench saw during one access
    int           o_cycles, o_nrd, o_nwr;
    logic         o_done, o_overlap, o_unstable, o_late_resp;
    logic [15:0]  o_rdata, o_raddr, o_waddr;
    logic [127:0] o_wdata;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] init_line(input int t);
        logic [127:0] l;
        for (int w = 0; w < 8; w++)
            l[w*16 +: 16] = 16'(t * 257 + w * 4951 + 3855);
        return l;
    endfunction

    function automatic logic [127:0] line_of(input int t);
        if (bmem.exists(t)) return bmem[t];
        return init_line(t);
    endfunction

    function automatic logic [15:0] wget(input logic [127:0] l, input int o);
        return l[o*16 +: 16];
    endfunction

    // drive one CPU request and play physical memory with fixed latency
    task automatic access(input logic [15:0] a, input logic rd, input logic wr,
                          input logic [1:0] be, input logic [15:0] wd,
                          input int lat);
        int           cnt = 0;
        logic         act = 1'b0;
        logic [15:0]  pa = '0;
        logic [127:0] pw = '0;
        mem_address = a; mem_read = rd; mem_write = wr;
        mem_byte_enable = be; mem_wdata = wd;
        o_cycles = -1; o_nrd = 0; o_nwr = 0; o_done = 1'b0;
        o_overlap = 1'b0; o_unstable = 1'b0;
        o_rdata = '0; o_raddr = '0; o_waddr = '0; o_wdata = '0;
        for (int c = 0; c < 200 && !o_done; c++) begin
            #1;
            if (pmem_read && pmem_write) o_overlap = 1'b1;
            if (pmem_read || pmem_write) begin
                if (!act) begin
                    cnt = 0; pa = pmem_address; pw = pmem_wdata;
                    if (pmem_read) begin
                        o_nrd++; o_raddr = pmem_address;
                    end else begin
                        o_nwr++; o_waddr = pmem_address; o_wdata = pmem_wdata;
                    end
                end else if (pmem_address !== pa || pmem_wdata !== pw) begin
                    o_unstable = 1'b1;
                end
                act = 1'b1;
                cnt++;
                if (cnt == lat) begin
                    pmem_resp  = 1'b1;
                    pmem_rdata = line_of(int'(pmem_address[15:4]));
                end
            end
            #1;
            if (mem_resp) begin
                o_done = 1'b1; o_cycles = c; o_rdata = mem_rdata;
            end
            @(posedge clk); #1;
            if (pmem_resp) act = 1'b0;
            pmem_resp  = 1'b0;
            pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
        end
        mem_read = 1'b0; mem_write = 1'b0;
        #1;
        o_late_resp = mem_resp;
        @(posedge clk); #1;
    endtask

    // predict from the line-level rules, run, compare, update model
    task automatic run(input logic [15:0] a, input logic rd, input logic wr,
                       input logic [1:0] be, input logic [15:0] wd,
                       input int lat);
        logic [11:0]  t = a[15:4];
        int           off = int'(a[3:1]);
        logic         h = mvalid && (mtag == t);
        logic [127:0] l, nl;
        logic [15:0]  w;
        int           e_nrd, e_nwr, e_lat;
        l  = h ? mline : line_of(int'(t));
        nl = l;
        if (wr) begin
            w = wget(l, off);
            if (be[0]) w[7:0]  = wd[7:0];
            if (be[1]) w[15:8] = wd[15:8];
            nl[off*16 +: 16] = w;
        end
        e_nrd = h ? 0 : 1;
        e_nwr = (wr && be != 2'b00) ? 1 : 0;
        e_lat = (h ? 0 : lat + 1) + (e_nwr == 1 ? lat : 0);
        if (h) mhits++;
        else   mmiss++;
        access(a, rd, wr, be, wd, lat);
        chk("done", 128'(o_done), 128'(1'b1));
        chk("latency", 128'(o_cycles), 128'(e_lat));
        chk("pmem_reads", 128'(o_nrd), 128'(e_nrd));
        if (e_nrd == 1) chk("fill_addr", 128'(o_raddr), 128'({t, 4'h0}));
        chk("pmem_writes", 128'(o_nwr), 128'(e_nwr));
        if (e_nwr == 1) begin
            chk("wr_addr", 128'(o_waddr), 128'({t, 4'h0}));
            chk("wr_data", o_wdata, nl);
        end
        if (!wr) chk("rdata", 128'(o_rdata), 128'(wget(nl, off)));
        chk("rd_wr_overlap", 128'(o_overlap), 128'(1'b0));
        chk("pmem_stable", 128'(o_unstable), 128'(1'b0));
        chk("resp_after_drop", 128'(o_late_resp), 128'(1'b0));
        mvalid = 1'b1; mtag = t; mline = nl;
        if (e_nwr == 1) bmem[int'(t)] = nl;
    endtask

    task automatic model_reset();
        mvalid = 1'b0; mtag = '0; mline = '0; mhits = 0; mmiss = 0;
    endtask

    initial begin
        logic [127:0] l0;
        logic [11:0]  pool [5];
        reset_n = 1'b0;
        mem_address = '0; mem_read = 1'b0; mem_write = 1'b0;
        mem_byte_enable = '0; mem_wdata = '0;
        pmem_rdata = '0; pmem_resp = 1'b0;
        model_reset();
        l0 = init_line(int'(12'h123));
        l0[47:32] = 16'hABCD;
        bmem[int'(12'h123)] = l0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_resp", 128'(mem_resp), 128'(1'b0));
        chk("rst_mem_rdata", 128'(mem_rdata), 128'(16'h0));
        chk("rst_pmem_read", 128'(pmem_read), 128'(1'b0));
        chk("rst_pmem_write", 128'(pmem_write), 128'(1'b0));
        chk("rst_pmem_address", 128'(pmem_address), 128'(16'h0));
        chk("rst_pmem_wdata", pmem_wdata, 128'h0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        run(16'h1234, 1'b1, 1'b0, 2'b00, 16'h0000, 3);
        chk("first_read_rdata", 128'(o_rdata), 128'(16'hABCD));
        run(16'h1230, 1'b1, 1'b0, 2'b00, 16'h0000, 2);
        run(16'h123E, 1'b1, 1'b0, 2'b00, 16'h0000, 2);
        run(16'h1234, 1'b0, 1'b1, 2'b11, 16'h1111, 2);
`ifdef MEM_LINE_BRIDGE_STATS_EN
        chk("miss_count_1", 128'(miss_count), 128'(16'd1));
        chk("hit_count_3", 128'(hit_count), 128'(16'd3));
`endif
        run(16'h1235, 1'b0, 1'b1, 2'b10, 16'h5A5A, 2);
        chk("byte_hi_word2", 128'(o_wdata[47:32]), 128'(16'h5A11));
        run(16'h2000, 1'b0, 1'b1, 2'b11, 16'hBEEF, 3);
        chk("write_miss_word0", 128'(o_wdata[15:0]), 128'(16'hBEEF));
        run(16'h2002, 1'b0, 1'b1, 2'b00, 16'h7777, 2);
        run(16'h2004, 1'b1, 1'b1, 2'b01, 16'hC3C3, 1);
        run(16'hFFFE, 1'b1, 1'b0, 2'b00, 16'h0000, 2);
        run(16'hFFF0, 1'b0, 1'b1, 2'b01, 16'h00A5, 1);

        // reset while a fill is outstanding
        mem_address = 16'h3456; mem_read = 1'b1;
        @(posedge clk); #2;
        chk("fill_started", 128'(pmem_read), 128'(1'b1));
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_fill_pmem_read", 128'(pmem_read), 128'(1'b0));
        chk("rst_fill_pmem_address", 128'(pmem_address), 128'(16'h0));
        chk("rst_fill_mem_rdata", 128'(mem_rdata), 128'(16'h0));
        mem_read = 1'b0;
        pmem_resp = 1'b1;
        pmem_rdata = {4{32'hDEADBEEF}};
        @(posedge clk); #1;
        pmem_resp = 1'b0;
        reset_n = 1'b1;
        @(posedge clk); #1;
        pmem_resp = 1'b1;
        @(posedge clk); #1;
        pmem_resp = 1'b0;
        #1;
        chk("late_resp_ignored", 128'(mem_rdata), 128'(16'h0));
        chk("late_resp_no_read", 128'(pmem_read), 128'(1'b0));
        @(posedge clk); #1;
        model_reset();
        mmiss = 1;
        run(16'h3456, 1'b1, 1'b0, 2'b00, 16'h0000, 2);
        chk("refill_after_reset", 128'(o_nrd), 128'(1));

        pool[0] = 12'h123; pool[1] = 12'h200; pool[2] = 12'hFFF;
        pool[3] = 12'h000; pool[4] = 12'h3A5;
        for (int i = 0; i < 60; i++) begin
            logic [15:0] a;
            int          k;
            k = int'($urandom_range(0, 3));
            a = {pool[$urandom_range(0, 4)], 4'($urandom)};
            run(a, k != 2, k >= 2, 2'($urandom), 16'($urandom),
                int'($urandom_range(1, 4)));
        end

`ifdef MEM_LINE_BRIDGE_STATS_EN
        chk("hit_count", 128'(hit_count), 128'(16'(mhits)));
        chk("miss_count", 128'(miss_count), 128'(16'(mmiss)));
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
